// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: two-phase FETCH/EXEC FSM that owns the PC, decodes
// opcode[15:11] and drives accumulator/ALU/RAM strobes only during EXEC.
module bip_control_unit #(
  parameter int PC_WIDTH  = 11,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic [PC_WIDTH-1:0]  prog_addr,
  input  logic [15:0]          prog_data,
  output logic [10:0]          operand,
  output logic [1:0]           sel_a,
  output logic                 sel_b,
  output logic                 op_sub,
  output logic                 wr_acc,
  output logic                 wr_ram,
  output logic                 rd_ram,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;

  logic [4:0] opcode;
  logic       op_illegal;

  assign opcode     = prog_data[15:11];
  assign op_illegal = (opcode[4:3] != 2'b00);

  // Controls are a pure function of the registered state, so an async reset
  // drops every strobe in the same instant it forces IDLE.
  always_comb begin
    operand = '0;
    sel_a   = 2'b00;
    sel_b   = 1'b0;
    op_sub  = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    if (state_q == S_EXEC) begin
      operand = prog_data[10:0];
      case (opcode)
        OP_STO:  wr_ram = 1'b1;
        OP_LD:   begin rd_ram = 1'b1; wr_acc = 1'b1; end
        OP_LDI:  begin wr_acc = 1'b1; sel_a = 2'b01; end
        OP_ADD:  begin rd_ram = 1'b1; wr_acc = 1'b1; sel_a = 2'b10; end
        OP_ADDI: begin wr_acc = 1'b1; sel_a = 2'b10; sel_b = 1'b1; end
        OP_SUB:  begin rd_ram = 1'b1; wr_acc = 1'b1; sel_a = 2'b10; op_sub = 1'b1; end
        OP_SUBI: begin wr_acc = 1'b1; sel_a = 2'b10; sel_b = 1'b1; op_sub = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (op_illegal) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + PC_ONE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = ((state_q == S_FETCH) || (state_q == S_EXEC)) ? cnt_q + CNT_ONE : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign prog_addr   = pc_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: decode vector table, directed corner sequences and
// randomized programs checked against an instruction-level reference model.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [10:0] prog_addr;
  logic [15:0] prog_data = 16'h0000;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op_sub, wr_acc, wr_ram, rd_ram, halted, illegal;
  logic [31:0] cycle_count;

  logic [15:0] mem [0:2047];

  int total = 0;
  int bad   = 0;

  bip_control_unit #(.PC_WIDTH(11), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .operand(operand), .sel_a(sel_a), .sel_b(sel_b), .op_sub(op_sub),
    .wr_acc(wr_acc), .wr_ram(wr_ram), .rd_ram(rd_ram),
    .halted(halted), .illegal(illegal), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // synchronous program memory: word appears one cycle after the address
  always @(posedge clk) prog_data <= mem[prog_addr];

  function automatic logic [6:0] ctrl_now();
    return {sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  // Reference: expected EXEC strobes {sel_a,sel_b,op_sub,wr_acc,wr_ram,rd_ram}
  function automatic logic [6:0] ref_ctrl(input logic [15:0] w);
    int op = int'(w[15:11]);
    logic [1:0] sa = 2'b00;
    logic sb = 0, sub = 0, wa = 0, wrm = 0, rrm = 0;
    if (op == 1) wrm = 1;
    if (op >= 2 && op <= 7) wa = 1;
    if (op == 2 || op == 4 || op == 6) rrm = 1;
    if (op == 3) sa = 2'b01;
    if (op >= 4 && op <= 7) sa = 2'b10;
    if (op == 5 || op == 7) sb = 1;
    if (op == 6 || op == 7) sub = 1;
    return {sa, sb, sub, wa, wrm, rrm};
  endfunction

  typedef struct {
    logic [15:0] word;
    logic [6:0]  ctrl;
    logic        ill;
    logic        hlt;
  } vec_t;

  vec_t vecs [11];

  // Runs one program from reset; run held low for idle_wait cycles first.
  task automatic run_program(input int idle_wait, input int len);
    int pc = 0;
    int cnt = 0;
    int n = 0;
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < idle_wait; i++) tick();
    check("rnd_idle_addr", 32'(prog_addr), 0);
    check("rnd_idle_cnt", cycle_count, 0);
    run = 1'b1;
    tick();
    forever begin
      w = mem[pc];
      check("rnd_fetch_addr", 32'(prog_addr), 32'(pc));
      check("rnd_fetch_ctrl", 32'(ctrl_now()), 0);
      check("rnd_cnt", cycle_count, 32'(cnt));
      run = 1'($urandom_range(0, 1));
      tick(); cnt++;
      check("rnd_exec_addr", 32'(prog_addr), 32'(pc));
      check("rnd_exec_ctrl", 32'(ctrl_now()), 32'(ref_ctrl(w)));
      check("rnd_exec_operand", 32'(operand), 32'(w[10:0]));
      tick(); cnt++; n++;
      if (w[15:11] == 5'd0 || w[15:11] > 5'd7) begin
        for (int k = 0; k < 3; k++) begin
          check("rnd_halted", 32'(halted), 1);
          check("rnd_illegal", 32'(illegal), 32'(w[15:11] != 5'd0));
          check("rnd_halt_pc", 32'(prog_addr), 32'(pc));
          check("rnd_halt_cnt", cycle_count, 32'(cnt));
          check("rnd_halt_ctrl", 32'(ctrl_now()), 0);
          tick();
        end
        break;
      end
      pc = (pc + 1) % 2048;
      if (n > len + 2) begin
        check("rnd_halt_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int wr_ram_n, wr_acc_n;
    logic [10:0] sto_opnd;

    vecs[0]  = '{16'h0000, 7'b00_0_0_0_0_0, 1'b0, 1'b1};
    vecs[1]  = '{16'h0801, 7'b00_0_0_0_1_0, 1'b0, 1'b0};
    vecs[2]  = '{16'h1005, 7'b00_0_0_1_0_1, 1'b0, 1'b0};
    vecs[3]  = '{16'h1FFF, 7'b01_0_0_1_0_0, 1'b0, 1'b0};
    vecs[4]  = '{16'h2003, 7'b10_0_0_1_0_1, 1'b0, 1'b0};
    vecs[5]  = '{16'h2807, 7'b10_1_0_1_0_0, 1'b0, 1'b0};
    vecs[6]  = '{16'h3004, 7'b10_0_1_1_0_1, 1'b0, 1'b0};
    vecs[7]  = '{16'h3803, 7'b10_1_1_1_0_0, 1'b0, 1'b0};
    vecs[8]  = '{16'h4000, 7'b00_0_0_0_0_0, 1'b1, 1'b1};
    vecs[9]  = '{16'hF800, 7'b00_0_0_0_0_0, 1'b1, 1'b1};
    vecs[10] = '{16'hFFFF, 7'b00_0_0_0_0_0, 1'b1, 1'b1};

    clear_mem();
    // async reset state, checked before any clock edge releases it
    #2;
    check("reset_addr", 32'(prog_addr), 0);
    check("reset_cnt", cycle_count, 0);
    check("reset_halted", 32'(halted), 0);
    check("reset_illegal", 32'(illegal), 0);
    check("reset_ctrl", 32'(ctrl_now()), 0);

    // run low keeps IDLE
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check("idle_addr", 32'(prog_addr), 0);
    check("idle_cnt", cycle_count, 0);
    check("idle_ctrl", 32'(ctrl_now()), 0);
    check("idle_halted", 32'(halted), 0);

    // decode table: word at addr 0, HALT at addr 1
    foreach (vecs[v]) begin
      clear_mem();
      mem[0] = vecs[v].word;
      do_reset();
      run = 1'b1;
      tick();
      check("vec_fetch_ctrl", 32'(ctrl_now()), 0);
      tick();
      check("vec_ctrl", 32'(ctrl_now()), 32'(vecs[v].ctrl));
      check("vec_operand", 32'(operand), 32'(vecs[v].word[10:0]));
      tick();
      check("vec_ctrl_once", 32'(ctrl_now()), 0);
      check("vec_halted", 32'(halted), 32'(vecs[v].hlt));
      check("vec_illegal", 32'(illegal), 32'(vecs[v].ill));
      check("vec_cnt", cycle_count, 2);
      check("vec_pc", 32'(prog_addr), vecs[v].hlt ? 0 : 1);
    end

    // reference program: LDI 4; STO 1; LDI 2; LD 1; ADD 1; HALT
    clear_mem();
    mem[0] = 16'h1804; mem[1] = 16'h0801; mem[2] = 16'h1802;
    mem[3] = 16'h1001; mem[4] = 16'h2001; mem[5] = 16'h0000;
    do_reset();
    run = 1'b1;
    tick();
    wr_ram_n = 0; wr_acc_n = 0; sto_opnd = '0;
    for (int c = 0; c < 12; c++) begin
      check("prog_addr_seq", 32'(prog_addr), 32'(c / 2));
      if (wr_ram) begin wr_ram_n++; sto_opnd = operand; end
      if (wr_acc) wr_acc_n++;
      if (c == 11) check("prog_not_yet_halted", 32'(halted), 0);
      tick();
    end
    check("prog_halted", 32'(halted), 1);
    check("prog_illegal", 32'(illegal), 0);
    check("prog_cnt", cycle_count, 12);
    check("prog_pc", 32'(prog_addr), 5);
    check("prog_wr_ram_n", 32'(wr_ram_n), 1);
    check("prog_sto_operand", 32'(sto_opnd), 1);
    check("prog_wr_acc_n", 32'(wr_acc_n), 4);
    run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("prog_frozen_cnt", cycle_count, 12);

    // PC wrap: every word an LDI
    for (int i = 0; i < 2048; i++) mem[i] = {5'b00011, 11'(i)};
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 2 * 2047; i++) tick();
    check("wrap_addr_top", 32'(prog_addr), 2047);
    tick(); tick();
    check("wrap_addr_zero", 32'(prog_addr), 0);
    check("wrap_cnt", cycle_count, 4096);

    // reset asserted during EXEC of STO
    clear_mem();
    mem[0] = 16'h1804; mem[1] = 16'h0801;
    do_reset();
    run = 1'b1;
    tick(); tick(); tick(); tick();
    check("sto_exec_wr_ram", 32'(wr_ram), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_wr_ram", 32'(wr_ram), 0);
    check("rst_mid_addr", 32'(prog_addr), 0);
    check("rst_mid_cnt", cycle_count, 0);
    run = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    check("rst_mid_idle_addr", 32'(prog_addr), 0);
    check("rst_mid_idle_cnt", cycle_count, 0);

    // randomized programs: legal body then HALT or an illegal opcode
    for (int t = 0; t < 25; t++) begin
      int len = $urandom_range(0, 30);
      clear_mem();
      for (int i = 0; i < len; i++)
        mem[i] = {5'($urandom_range(1, 7)), 11'($urandom)};
      if ($urandom_range(0, 1) == 0) mem[len] = {5'd0, 11'($urandom)};
      else mem[len] = {5'($urandom_range(8, 31)), 11'($urandom)};
      run_program($urandom_range(0, 4), len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
